// File: rtl/reg_rd.sv
// reg_rd: operand fetch with same-cycle write-back bypass, pending-write scoreboard and registered valid/ready output.
// Latency 1 cycle request->operands; optional `REG_RD_R0_ZERO_EN makes register 0 read as zero and never pend.
module reg_rd #(
    parameter int DATA_W = 16
) (
    input  logic              CLK_RD,
    input  logic              RESET,
    input  logic [DATA_W-1:0] REG_0,
    input  logic [DATA_W-1:0] REG_1,
    input  logic [DATA_W-1:0] REG_2,
    input  logic [DATA_W-1:0] REG_3,
    input  logic [DATA_W-1:0] REG_4,
    input  logic [DATA_W-1:0] REG_5,
    input  logic [DATA_W-1:0] REG_6,
    input  logic [DATA_W-1:0] REG_7,
    input  logic [2:0]        N_REG,
    input  logic [DATA_W-1:0] REG_IN,
    input  logic              REG_WEN,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [2:0]        REQ_A,
    input  logic [2:0]        REQ_B,
    input  logic [2:0]        REQ_DST,
    input  logic              REQ_DST_EN,
    output logic              OP_VALID,
    input  logic              OP_READY,
    output logic [DATA_W-1:0] OP_A,
    output logic [DATA_W-1:0] OP_B,
    output logic [2:0]        OP_DST,
    output logic              OP_DST_EN
);

    logic [DATA_W-1:0] rf [8];
    logic [7:0]        wb_clr;
    logic [7:0]        eff_pend;
    logic [7:0]        set_mask;
    logic              hazard;
    logic              space;
    logic              req_rdy;
    logic              accept;
    logic              dst_en_eff;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    logic              op_vld_q,    op_vld_d;
    logic [DATA_W-1:0] op_a_q,      op_a_d;
    logic [DATA_W-1:0] op_b_q,      op_b_d;
    logic [2:0]        op_dst_q,    op_dst_d;
    logic              op_dst_en_q, op_dst_en_d;
    logic [7:0]        pend_q,      pend_d;

    always_comb begin
        rf[0] = REG_0;
        rf[1] = REG_1;
        rf[2] = REG_2;
        rf[3] = REG_3;
        rf[4] = REG_4;
        rf[5] = REG_5;
        rf[6] = REG_6;
        rf[7] = REG_7;
    end

    // A write-back committing this edge both clears its pending bit and feeds the bypass.
    always_comb begin
        wb_clr = 8'h00;
        if (REG_WEN) begin
            wb_clr[N_REG] = 1'b1;
        end
    end

    assign eff_pend = pend_q & ~wb_clr;

`ifdef REG_RD_R0_ZERO_EN
    assign dst_en_eff = REQ_DST_EN && (REQ_DST != 3'd0);
`else
    assign dst_en_eff = REQ_DST_EN;
`endif

    // Destination term catches WAW so two writers of one register never overlap.
    assign hazard  = eff_pend[REQ_A] | eff_pend[REQ_B] | (REQ_DST_EN & eff_pend[REQ_DST]);
    assign space   = !op_vld_q | OP_READY;
    assign req_rdy = !RESET & REQ_VALID & !hazard & space;
    assign accept  = REQ_VALID & req_rdy;

    always_comb begin
        sel_a = rf[REQ_A];
        if (REG_WEN && (N_REG == REQ_A)) begin
            sel_a = REG_IN;
        end
`ifdef REG_RD_R0_ZERO_EN
        if (REQ_A == 3'd0) begin
            sel_a = '0;
        end
`endif
    end

    always_comb begin
        sel_b = rf[REQ_B];
        if (REG_WEN && (N_REG == REQ_B)) begin
            sel_b = REG_IN;
        end
`ifdef REG_RD_R0_ZERO_EN
        if (REQ_B == 3'd0) begin
            sel_b = '0;
        end
`endif
    end

    // Set is ORed after the clear so a same-cycle set on a clearing register wins.
    always_comb begin
        set_mask = 8'h00;
        if (accept && dst_en_eff) begin
            set_mask[REQ_DST] = 1'b1;
        end
    end

    always_comb begin
        op_vld_d    = op_vld_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_dst_d    = op_dst_q;
        op_dst_en_d = op_dst_en_q;
        pend_d      = eff_pend | set_mask;
        if (accept) begin
            op_vld_d    = 1'b1;
            op_a_d      = sel_a;
            op_b_d      = sel_b;
            op_dst_d    = REQ_DST;
            op_dst_en_d = dst_en_eff;
        end else if (OP_READY && op_vld_q) begin
            op_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_RD) begin
        if (RESET) begin
            op_vld_q    <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_dst_q    <= 3'd0;
            op_dst_en_q <= 1'b0;
            pend_q      <= 8'h00;
        end else begin
            op_vld_q    <= op_vld_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_dst_q    <= op_dst_d;
            op_dst_en_q <= op_dst_en_d;
            pend_q      <= pend_d;
        end
    end

    assign REQ_READY = req_rdy;
    assign OP_VALID  = op_vld_q;
    assign OP_A      = op_a_q;
    assign OP_B      = op_b_q;
    assign OP_DST    = op_dst_q;
    assign OP_DST_EN = op_dst_en_q;

endmodule

// File: tb/tb_reg_rd.sv
// Directed-vector bench for reg_rd: reset, fetch, bypass, RAW/WAW stalls, backpressure, scoreboard set/clear, reset mid-stream.
module tb_reg_rd;

    localparam int DATA_W = 16;

    logic              CLK_RD = 1'b0;
    logic              RESET;
    logic [DATA_W-1:0] REG_0, REG_1, REG_2, REG_3, REG_4, REG_5, REG_6, REG_7;
    logic [2:0]        N_REG;
    logic [DATA_W-1:0] REG_IN;
    logic              REG_WEN;
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [2:0]        REQ_A, REQ_B, REQ_DST;
    logic              REQ_DST_EN;
    logic              OP_VALID;
    logic              OP_READY;
    logic [DATA_W-1:0] OP_A, OP_B;
    logic [2:0]        OP_DST;
    logic              OP_DST_EN;

    int n_vec = 0;
    int n_err = 0;

    reg_rd #(.DATA_W(DATA_W)) dut (
        .CLK_RD(CLK_RD), .RESET(RESET),
        .REG_0(REG_0), .REG_1(REG_1), .REG_2(REG_2), .REG_3(REG_3),
        .REG_4(REG_4), .REG_5(REG_5), .REG_6(REG_6), .REG_7(REG_7),
        .N_REG(N_REG), .REG_IN(REG_IN), .REG_WEN(REG_WEN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_DST(REQ_DST), .REQ_DST_EN(REQ_DST_EN),
        .OP_VALID(OP_VALID), .OP_READY(OP_READY),
        .OP_A(OP_A), .OP_B(OP_B), .OP_DST(OP_DST), .OP_DST_EN(OP_DST_EN)
    );

    always #5 CLK_RD = ~CLK_RD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_RD);
        #1;
    endtask

    task automatic req(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d, input logic den);
        REQ_VALID  = 1'b1;
        REQ_A      = a;
        REQ_B      = b;
        REQ_DST    = d;
        REQ_DST_EN = den;
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        REG_0 = 16'h0000; REG_1 = 16'h0000; REG_2 = 16'h0000; REG_3 = 16'h0000;
        REG_4 = 16'h0000; REG_5 = 16'h0000; REG_6 = 16'h0000; REG_7 = 16'h0000;
        N_REG = 3'd0; REG_IN = '0; REG_WEN = 1'b0;
        REQ_VALID = 1'b1; REQ_A = 3'd1; REQ_B = 3'd2; REQ_DST = 3'd0; REQ_DST_EN = 1'b0;
        OP_READY = 1'b1;
        tick();
        tick();
        chk("rst_op_valid", 32'(OP_VALID), 32'd0);
        chk("rst_op_a", 32'(OP_A), 32'h0);
        chk("rst_op_b", 32'(OP_B), 32'h0);
        chk("rst_op_dst_en", 32'(OP_DST_EN), 32'd0);
        chk("rst_req_ready", 32'(REQ_READY), 32'd0);
        chk("rst_pend", 32'(dut.pend_q), 32'h00);

        // basic fetch
        RESET = 1'b0;
        REG_1 = 16'h1111; REG_2 = 16'h2222;
        req(3'd1, 3'd2, 3'd0, 1'b0);
        chk("fetch_ready", 32'(REQ_READY), 32'd1);
        tick();
        chk("fetch_valid", 32'(OP_VALID), 32'd1);
        chk("fetch_a", 32'(OP_A), 32'h1111);
        chk("fetch_b", 32'(OP_B), 32'h2222);

        // bypass, with A==B
        REG_WEN = 1'b1; N_REG = 3'd3; REG_IN = 16'hbeaf;
        req(3'd3, 3'd3, 3'd0, 1'b0);
        chk("byp_ready", 32'(REQ_READY), 32'd1);
        tick();
        REG_WEN = 1'b0;
        chk("byp_a", 32'(OP_A), 32'hbeaf);
        chk("byp_b", 32'(OP_B), 32'hbeaf);

        // RAW on register 5
        req(3'd1, 3'd2, 3'd5, 1'b1);
        tick();
        chk("raw_dst", 32'(OP_DST), 32'd5);
        chk("raw_dst_en", 32'(OP_DST_EN), 32'd1);
        chk("raw_pend_set", 32'(dut.pend_q), 32'h20);
        req(3'd5, 3'd1, 3'd0, 1'b0);
        chk("raw_stall0", 32'(REQ_READY), 32'd0);
        tick();
        chk("raw_drain_valid", 32'(OP_VALID), 32'd0);
        chk("raw_hold_a", 32'(OP_A), 32'h1111);
        chk("raw_stall1", 32'(REQ_READY), 32'd0);
        REG_WEN = 1'b1; N_REG = 3'd5; REG_IN = 16'h1234;
        #1;
        chk("raw_release", 32'(REQ_READY), 32'd1);
        tick();
        REG_WEN = 1'b0;
        chk("raw_a", 32'(OP_A), 32'h1234);
        chk("raw_b", 32'(OP_B), 32'h1111);
        chk("raw_pend_clr", 32'(dut.pend_q), 32'h00);

        // backpressure
        OP_READY = 1'b0;
        req(3'd2, 3'd1, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 32'(REQ_READY), 32'd0);
            tick();
            chk("bp_valid", 32'(OP_VALID), 32'd1);
            chk("bp_hold_a", 32'(OP_A), 32'h1234);
            chk("bp_hold_b", 32'(OP_B), 32'h1111);
        end
        OP_READY = 1'b1;
        #1;
        chk("bp_release", 32'(REQ_READY), 32'd1);
        tick();
        chk("bp_a", 32'(OP_A), 32'h2222);
        chk("bp_b", 32'(OP_B), 32'h1111);

        // simultaneous clear and set on register 4
        req(3'd1, 3'd2, 3'd4, 1'b1);
        tick();
        chk("cs_pend_pre", 32'(dut.pend_q), 32'h10);
        REG_WEN = 1'b1; N_REG = 3'd4; REG_IN = 16'h4444;
        req(3'd1, 3'd2, 3'd4, 1'b1);
        chk("cs_ready", 32'(REQ_READY), 32'd1);
        tick();
        REG_WEN = 1'b0;
        chk("cs_pend_post", 32'(dut.pend_q), 32'h10);
        req(3'd4, 3'd1, 3'd0, 1'b0);
        chk("cs_stall_a4", 32'(REQ_READY), 32'd0);

        // build PEND=8'h24, check WAW, then reset mid-stream
        REG_WEN = 1'b1; N_REG = 3'd4;
        req(3'd1, 3'd1, 3'd2, 1'b1);
        tick();
        REG_WEN = 1'b0;
        REG_6 = 16'h6666;
        req(3'd6, 3'd1, 3'd5, 1'b1);
        tick();
        chk("mid_pend", 32'(dut.pend_q), 32'h24);
        chk("mid_valid", 32'(OP_VALID), 32'd1);
        chk("self_dst_a", 32'(OP_A), 32'h6666);
        req(3'd1, 3'd1, 3'd5, 1'b1);
        chk("waw_stall", 32'(REQ_READY), 32'd0);
        req(3'd1, 3'd1, 3'd5, 1'b0);
        chk("waw_no_dst", 32'(REQ_READY), 32'd1);
        OP_READY = 1'b0;
        REQ_VALID = 1'b0;
        RESET = 1'b1;
        REG_WEN = 1'b1; N_REG = 3'd2; REG_IN = 16'h0202;
        tick();
        chk("mrst_valid", 32'(OP_VALID), 32'd0);
        chk("mrst_pend", 32'(dut.pend_q), 32'h00);
        chk("mrst_a", 32'(OP_A), 32'h0);
        chk("mrst_dst", 32'(OP_DST), 32'd0);
        RESET = 1'b0; REG_WEN = 1'b0; OP_READY = 1'b1;
        req(3'd5, 3'd2, 3'd0, 1'b0);
        chk("post_rst_ready", 32'(REQ_READY), 32'd1);
        tick();
        chk("post_rst_pend", 32'(dut.pend_q), 32'h00);

        // register 0 behaviour
        REG_0 = 16'hffff;
        REG_WEN = 1'b1; N_REG = 3'd0; REG_IN = 16'hf00d;
        req(3'd0, 3'd0, 3'd0, 1'b1);
        tick();
        REG_WEN = 1'b0;
`ifdef REG_RD_R0_ZERO_EN
        chk("r0_a", 32'(OP_A), 32'h0);
        chk("r0_dst_en", 32'(OP_DST_EN), 32'd0);
        chk("r0_pend", 32'(dut.pend_q), 32'h00);
`else
        chk("r0_a", 32'(OP_A), 32'hf00d);
        chk("r0_dst_en", 32'(OP_DST_EN), 32'd1);
        chk("r0_pend", 32'(dut.pend_q), 32'h01);
`endif
        REQ_VALID = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_rd.md
Name: reg_rd

Overview:
- Operand-fetch (register read) stage; the read-side counterpart of the register write-back block.
- Accepts a decoded read request (two source register numbers plus an optional destination) and selects operands from the eight architectural registers.
- Applies same-cycle write-back bypass and a per-register pending-write scoreboard, then presents operands to execute through a registered valid/ready output stage.

Parameters:
DATA_W, 16, register/operand width.

Ports:
CLK_RD  in  1  stage clock; same net as the write-back clock.
RESET  in  1  synchronous, active-high reset.
REG_0..REG_7  in  DATA_W each  architectural register contents from write-back.
N_REG  in  3  write-back target register number.
REG_IN  in  DATA_W  write-back data.
REG_WEN  in  1  write-back enable; a write commits at this CLK_RD edge.
REQ_VALID  in  1  read request valid.
REQ_READY  out  1  request accepted this cycle (combinational).
REQ_A  in  3  source A register number.
REQ_B  in  3  source B register number.
REQ_DST  in  3  destination register number of the requesting instruction.
REQ_DST_EN  in  1  instruction will write REQ_DST.
OP_VALID  out  1  operands valid.
OP_READY  in  1  execute consumes operands.
OP_A  out  DATA_W  source A operand.
OP_B  out  DATA_W  source B operand.
OP_DST  out  3  registered copy of REQ_DST.
OP_DST_EN  out  1  registered copy of REQ_DST_EN.

Behaviour:
- Reset (synchronous, RESET=1 at an edge): OP_VALID=0, OP_A=0, OP_B=0, OP_DST=0, OP_DST_EN=0, scoreboard PEND[7:0]=0. REQ_READY=0 while RESET=1.
- wb_clr[i] = REG_WEN && N_REG==i. eff_pend = PEND & ~wb_clr.
- Hazard = eff_pend[REQ_A] | eff_pend[REQ_B] | (REQ_DST_EN & eff_pend[REQ_DST]). The REQ_DST term stalls WAW hazards.
- Space = !OP_VALID | OP_READY.
- REQ_READY = !RESET & REQ_VALID & !Hazard & Space.
- Operand select, per source: if REG_WEN && N_REG==src, take REG_IN (bypass); otherwise take REG_src.
- On accept (REQ_VALID & REQ_READY):
  - Capture OP_A, OP_B, OP_DST, OP_DST_EN.
  - OP_VALID=1 next cycle. Latency is one cycle from request to operands.
- If not accepting and OP_READY & OP_VALID: OP_VALID=0. Data outputs hold their last value.
- OP_* is stable while OP_VALID & !OP_READY.
- Scoreboard next state: PEND_next = (PEND & ~wb_clr) | (accept & REQ_DST_EN ? onehot(REQ_DST) : 0).
  - Set and clear on the same register in the same cycle: set wins.
- Write-back with no pending bit set (e.g. an external write) simply updates data. The bypass still applies; no error.
- REQ_A==REQ_B is legal; both outputs carry the same value.
- A source equal to its own REQ_DST is legal; it reads the old value and then sets PEND.
- Reset mid-operation drops any held operand and clears all PEND bits. In-flight write-backs after reset do not re-set PEND.
- Throughput: one request per cycle when there is no hazard and OP_READY=1.

Optional Feature:
REG_RD_R0_ZERO_EN:
- Defined:
  - A source of register 0 always yields 0; REG_0 and the bypass are ignored.
  - PEND[0] is never set, so register 0 never causes a hazard.
  - OP_DST_EN is forced to 0 when REQ_DST==0.
- Undefined: register 0 behaves like every other register.

Test Plan:
1. Reset, then REG_1=16'h1111, REG_2=16'h2222, request A=1, B=2, DST_EN=0, OP_READY=1 -> next cycle OP_VALID=1, OP_A=16'h1111, OP_B=16'h2222.
2. Bypass: request A=3 while REG_WEN=1, N_REG=3, REG_IN=16'hbeaf and REG_3=16'h0000 -> OP_A=16'hbeaf.
3. RAW: accept DST=5 with DST_EN=1, then request A=5 -> REQ_READY=0 until a cycle with REG_WEN=1, N_REG=5, REG_IN=16'h1234. Accepted that same cycle with OP_A=16'h1234, and PEND[5]=0 afterwards.
4. Backpressure: OP_READY=0 with OP_VALID=1 -> REQ_READY=0 and OP_A/OP_B unchanged for 3 cycles. Raising OP_READY accepts the next request the same cycle.
5. Simultaneous clear and set: PEND[4]=1, write-back to 4 and accept of a new DST=4 in the same cycle -> PEND[4]=1 afterwards.
6. RESET=1 mid-stream with OP_VALID=1 and PEND=8'h24 -> next cycle OP_VALID=0, PEND=0, OP_A=0. With REG_RD_R0_ZERO_EN defined, A=0 and REG_0=16'hffff -> OP_A=0.
